// File: rtl/uart_cmd_parser.sv
// Byte-stream command parser: validates CMD,V0,V1,TERM frames from a UART receiver and commits them.
// Optional per-frame/error statistics counters are enabled with the PARSER_STATS_EN macro.
module uart_cmd_parser #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] chr_cmd,
    output logic [7:0] chr_val0,
    output logic [7:0] chr_val1,
    output logic       rx_msg_done,
    output logic       frame_err
`ifdef PARSER_STATS_EN
    ,
    output logic [7:0] frame_cnt,
    output logic [7:0] err_cnt
`endif
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TIMEOUT_MAX = CW'(TIMEOUT_CYCLES);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] GOT_CMD = 3'd1;
    localparam logic [2:0] GOT_V0  = 3'd2;
    localparam logic [2:0] GOT_V1  = 3'd3;
    localparam logic [2:0] DISCARD = 3'd4;

    logic [2:0]    state;
    logic [2:0]    state_next;
    logic [CW-1:0] tmo_cnt;
    logic [7:0]    cmd_buf;
    logic [7:0]    v0_buf;
    logic [7:0]    v1_buf;
    logic          err_next;
    logic          commit;
    logic          timeout;

    function automatic logic is_term(input logic [7:0] b);
        return (b == 8'h0A) || (b == 8'h0D);
    endfunction

    function automatic logic is_cmd(input logic [7:0] b);
        return ((b >= 8'h41) && (b <= 8'h44)) || (b == 8'h4C);
    endfunction

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    function automatic logic is_bit(input logic [7:0] b);
        return (b == 8'h30) || (b == 8'h31);
    endfunction

    // A byte arriving on the expiry cycle takes precedence over the timeout.
    always_comb begin
        state_next = state;
        err_next   = 1'b0;
        commit     = 1'b0;
        timeout    = (state != IDLE) && (tmo_cnt == TIMEOUT_MAX);
        if (rx_valid) begin
            case (state)
                IDLE: begin
                    if (is_cmd(rx_data)) begin
                        state_next = GOT_CMD;
                    end else if (!is_term(rx_data)) begin
                        state_next = DISCARD;
                        err_next   = 1'b1;
                    end
                end
                GOT_CMD: begin
                    if ((cmd_buf == 8'h4C) ? is_bit(rx_data)
                                           : (is_digit(rx_data) || rx_data == 8'h2D)) begin
                        state_next = GOT_V0;
                    end else begin
                        state_next = DISCARD;
                        err_next   = 1'b1;
                    end
                end
                GOT_V0: begin
                    if ((cmd_buf == 8'h4C) ? is_bit(rx_data) : is_digit(rx_data)) begin
                        state_next = GOT_V1;
                    end else begin
                        state_next = DISCARD;
                        err_next   = 1'b1;
                    end
                end
                GOT_V1: begin
                    if (is_term(rx_data)) begin
                        state_next = IDLE;
                        commit     = 1'b1;
                    end else begin
                        state_next = DISCARD;
                        err_next   = 1'b1;
                    end
                end
                DISCARD: begin
                    if (is_term(rx_data)) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end else if (timeout) begin
            state_next = IDLE;
            err_next   = (state != DISCARD);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            frame_err <= err_next;
            if (rx_valid || state == IDLE) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt != TIMEOUT_MAX) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

    // Frame bytes are staged here so the outputs only ever show a complete, checked frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_buf     <= 8'h20;
            v0_buf      <= 8'h20;
            v1_buf      <= 8'h20;
            chr_cmd     <= 8'h20;
            chr_val0    <= 8'h20;
            chr_val1    <= 8'h20;
            rx_msg_done <= 1'b0;
        end else begin
            if (rx_valid && state == IDLE)    cmd_buf <= rx_data;
            if (rx_valid && state == GOT_CMD) v0_buf  <= rx_data;
            if (rx_valid && state == GOT_V0)  v1_buf  <= rx_data;
            if (commit) begin
                chr_cmd     <= cmd_buf;
                chr_val0    <= v0_buf;
                chr_val1    <= v1_buf;
                rx_msg_done <= 1'b1;
            end else if (rx_valid) begin
                rx_msg_done <= 1'b0;
            end
        end
    end

`ifdef PARSER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= 8'h00;
            err_cnt   <= 8'h00;
        end else begin
            if (commit && frame_cnt != 8'hFF)  frame_cnt <= frame_cnt + 8'h01;
            if (err_next && err_cnt != 8'hFF)  err_cnt   <= err_cnt + 8'h01;
        end
    end
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: vector table plus timeout, reset and (with PARSER_STATS_EN) counter sequences.
module tb_uart_cmd_parser;

    localparam int TMO = 20;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] chr_cmd;
    logic [7:0] chr_val0;
    logic [7:0] chr_val1;
    logic       rx_msg_done;
    logic       frame_err;
`ifdef PARSER_STATS_EN
    logic [7:0] frame_cnt;
    logic [7:0] err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        logic [7:0] cmd;
        logic [7:0] v0;
        logic [7:0] v1;
        logic       done;
        logic       err;
    } vec_t;

    vec_t vecs[80];
    int   nvec = 0;

    uart_cmd_parser #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .chr_cmd    (chr_cmd),
        .chr_val0   (chr_val0),
        .chr_val1   (chr_val1),
        .rx_msg_done(rx_msg_done),
        .frame_err  (frame_err)
`ifdef PARSER_STATS_EN
        ,
        .frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_frame(input string name, input logic [7:0] c, input logic [7:0] a,
                               input logic [7:0] b, input logic d, input logic e);
        check_output({name, ".cmd"}, {8'h00, chr_cmd}, {8'h00, c});
        check_output({name, ".val0"}, {8'h00, chr_val0}, {8'h00, a});
        check_output({name, ".val1"}, {8'h00, chr_val1}, {8'h00, b});
        check_output({name, ".done"}, {15'h0, rx_msg_done}, {15'h0, d});
        check_output({name, ".err"}, {15'h0, frame_err}, {15'h0, e});
    endtask

    // Drives one byte strobe; returns on the falling edge after the accepting rising edge.
    task automatic apply_stimulus(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] t);
        apply_stimulus(c);
        apply_stimulus(a);
        apply_stimulus(b);
        apply_stimulus(t);
    endtask

    task automatic add_vec(input logic [7:0] d, input logic [7:0] c, input logic [7:0] a,
                           input logic [7:0] b, input logic dn, input logic e);
        vecs[nvec].data = d;
        vecs[nvec].cmd  = c;
        vecs[nvec].v0   = a;
        vecs[nvec].v1   = b;
        vecs[nvec].done = dn;
        vecs[nvec].err  = e;
        nvec++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int pulses;
        int pulse_at;

        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        // "A18\n" then "L10\r", 'B' dropping done, then a set of malformed frames.
        add_vec(8'h41, 8'h20, 8'h20, 8'h20, 0, 0);
        add_vec(8'h31, 8'h20, 8'h20, 8'h20, 0, 0);
        add_vec(8'h38, 8'h20, 8'h20, 8'h20, 0, 0);
        add_vec(8'h0A, 8'h41, 8'h31, 8'h38, 1, 0);
        add_vec(8'h4C, 8'h41, 8'h31, 8'h38, 0, 0);
        add_vec(8'h31, 8'h41, 8'h31, 8'h38, 0, 0);
        add_vec(8'h30, 8'h41, 8'h31, 8'h38, 0, 0);
        add_vec(8'h0D, 8'h4C, 8'h31, 8'h30, 1, 0);
        add_vec(8'h42, 8'h4C, 8'h31, 8'h30, 0, 0);
        add_vec(8'h58, 8'h4C, 8'h31, 8'h30, 0, 1);
        add_vec(8'h0A, 8'h4C, 8'h31, 8'h30, 0, 0);
        add_vec(8'h58, 8'h4C, 8'h31, 8'h30, 0, 1);
        add_vec(8'h31, 8'h4C, 8'h31, 8'h30, 0, 0);
        add_vec(8'h32, 8'h4C, 8'h31, 8'h30, 0, 0);
        add_vec(8'h0A, 8'h4C, 8'h31, 8'h30, 0, 0);
        add_vec(8'h41, 8'h4C, 8'h31, 8'h30, 0, 0);
        add_vec(8'h31, 8'h4C, 8'h31, 8'h30, 0, 0);
        add_vec(8'h32, 8'h4C, 8'h31, 8'h30, 0, 0);
        add_vec(8'h33, 8'h4C, 8'h31, 8'h30, 0, 1);
        add_vec(8'h0A, 8'h4C, 8'h31, 8'h30, 0, 0);
        add_vec(8'h4C, 8'h4C, 8'h31, 8'h30, 0, 0);
        add_vec(8'h32, 8'h4C, 8'h31, 8'h30, 0, 1);
        add_vec(8'h0A, 8'h4C, 8'h31, 8'h30, 0, 0);
        add_vec(8'h41, 8'h4C, 8'h31, 8'h30, 0, 0);
        add_vec(8'h2D, 8'h4C, 8'h31, 8'h30, 0, 0);
        add_vec(8'h2D, 8'h4C, 8'h31, 8'h30, 0, 1);
        add_vec(8'h0A, 8'h4C, 8'h31, 8'h30, 0, 0);
        add_vec(8'h42, 8'h4C, 8'h31, 8'h30, 0, 0);
        add_vec(8'h41, 8'h4C, 8'h31, 8'h30, 0, 1);
        add_vec(8'h0A, 8'h4C, 8'h31, 8'h30, 0, 0);
        add_vec(8'h0A, 8'h4C, 8'h31, 8'h30, 0, 0);
        add_vec(8'h44, 8'h4C, 8'h31, 8'h30, 0, 0);
        add_vec(8'h2D, 8'h4C, 8'h31, 8'h30, 0, 0);
        add_vec(8'h35, 8'h4C, 8'h31, 8'h30, 0, 0);
        add_vec(8'h0D, 8'h44, 8'h2D, 8'h35, 1, 0);
        add_vec(8'h0A, 8'h44, 8'h2D, 8'h35, 0, 0);
        add_vec(8'h4C, 8'h44, 8'h2D, 8'h35, 0, 0);
        add_vec(8'h31, 8'h44, 8'h2D, 8'h35, 0, 0);
        add_vec(8'h31, 8'h44, 8'h2D, 8'h35, 0, 0);
        add_vec(8'h0A, 8'h4C, 8'h31, 8'h31, 1, 0);
        add_vec(8'h43, 8'h4C, 8'h31, 8'h31, 0, 0);
        add_vec(8'h30, 8'h4C, 8'h31, 8'h31, 0, 0);
        add_vec(8'h30, 8'h4C, 8'h31, 8'h31, 0, 0);
        add_vec(8'h0A, 8'h43, 8'h30, 8'h30, 1, 0);

        repeat (3) @(negedge clk);
        check_frame("reset", 8'h20, 8'h20, 8'h20, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < nvec; i++) begin
            apply_stimulus(vecs[i].data);
            check_frame($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].v0, vecs[i].v1,
                        vecs[i].done, vecs[i].err);
        end

        // Timeout out of GOT_V0: exactly one pulse, TMO+1 cycles after the last byte.
        apply_stimulus(8'h43);
        apply_stimulus(8'h33);
        pulses   = 0;
        pulse_at = 0;
        for (int i = 1; i <= TMO + 5; i++) begin
            @(negedge clk);
            if (frame_err) begin
                pulses++;
                pulse_at = i;
            end
        end
        check_output("tmo.pulses", 16'(pulses), 16'd1);
        check_output("tmo.when", 16'(pulse_at), 16'(TMO + 1));
        apply_stimulus(8'h44);
        check_output("tmo.idle_after", {15'h0, frame_err}, 16'h0);
        apply_stimulus(8'h2D);
        apply_stimulus(8'h35);
        apply_stimulus(8'h0A);
        check_frame("tmo.d_5", 8'h44, 8'h2D, 8'h35, 1, 0);

        // Byte arriving on the expiry cycle wins over the timeout.
        apply_stimulus(8'h41);
        apply_stimulus(8'h31);
        pulses = 0;
        for (int i = 0; i < TMO - 1; i++) begin
            @(negedge clk);
            if (frame_err) pulses++;
        end
        apply_stimulus(8'h32);
        check_output("race.err", {15'h0, frame_err}, 16'h0);
        check_output("race.pulses", 16'(pulses), 16'd0);
        apply_stimulus(8'h0A);
        check_frame("race.commit", 8'h41, 8'h31, 8'h32, 1, 0);

        // Timeout out of DISCARD is silent.
        apply_stimulus(8'h58);
        check_output("disc.err", {15'h0, frame_err}, 16'h1);
        pulses = 0;
        for (int i = 0; i < TMO + 5; i++) begin
            @(negedge clk);
            if (frame_err) pulses++;
        end
        check_output("disc.tmo_pulses", 16'(pulses), 16'd0);
        send_frame(8'h41, 8'h35, 8'h35, 8'h0A);
        check_frame("disc.commit", 8'h41, 8'h35, 8'h35, 1, 0);

        // Reset in the middle of "B0".
        apply_stimulus(8'h42);
        apply_stimulus(8'h30);
        rst_n = 1'b0;
        #1;
        check_frame("rst.async", 8'h20, 8'h20, 8'h20, 0, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < TMO + 5; i++) begin
            @(negedge clk);
            if (frame_err) pulses++;
        end
        check_output("rst.no_err", 16'(pulses), 16'd0);
        send_frame(8'h42, 8'h37, 8'h39, 8'h0D);
        check_frame("rst.commit", 8'h42, 8'h37, 8'h39, 1, 0);

`ifdef PARSER_STATS_EN
        do_reset();
        check_output("stats.frame_rst", {8'h00, frame_cnt}, 16'h0000);
        check_output("stats.err_rst", {8'h00, err_cnt}, 16'h0000);
        send_frame(8'h41, 8'h31, 8'h33, 8'h0A);
        send_frame(8'h58, 8'h31, 8'h32, 8'h0A);
        send_frame(8'h4C, 8'h33, 8'h30, 8'h0A);
        check_output("stats.err2", {8'h00, err_cnt}, 16'h0002);
        check_output("stats.frame1", {8'h00, frame_cnt}, 16'h0001);
        for (int i = 0; i < 299; i++) send_frame(8'h41, 8'h30, 8'h30, 8'h0A);
        check_output("stats.frame_sat", {8'h00, frame_cnt}, 16'h00FF);
        check_output("stats.err_hold", {8'h00, err_cnt}, 16'h0002);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 100000: idle cycles between bytes before a partial frame is dropped (100 ms at 1 MHz).
REQ-002 clk  input  1  system clock, 1 MHz.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 rx_data  input  8  byte from UART receiver, valid only when rx_valid=1.
REQ-005 rx_valid  input  1  one-cycle strobe; each high cycle is exactly one byte.
REQ-006 chr_cmd  output  8  command byte of last valid frame.
REQ-007 chr_val0  output  8  first value byte of last valid frame.
REQ-008 chr_val1  output  8  second value byte of last valid frame.
REQ-009 rx_msg_done  output  1  level, high from valid-frame completion until the next accepted byte.
REQ-010 frame_err  output  1  one-cycle pulse on a malformed or timed-out frame.

Function
REQ-011 Frame format: CMD, V0, V1, TERM; TERM is 0x0A or 0x0D.
REQ-012 CMD is legal only if it is one of 'A' 'B' 'C' 'D' 'L' (0x41-0x44, 0x4C).
REQ-013 Value rules for A-D: V0 is '0'-'9' or '-' (0x2D); V1 is '0'-'9'.
REQ-014 Value rules for L: V0 and V1 are each '0' or '1'.
REQ-015 FSM states: IDLE, GOT_CMD, GOT_V0, GOT_V1, DISCARD.
REQ-016 IDLE: TERM is ignored; legal CMD goes to GOT_CMD; any other byte goes to DISCARD and pulses frame_err.
REQ-017 GOT_CMD: legal V0 goes to GOT_V0; otherwise DISCARD plus frame_err.
REQ-018 GOT_V0: legal V1 goes to GOT_V1; otherwise DISCARD plus frame_err.
REQ-019 GOT_V1: TERM goes to IDLE and commits the frame; any other byte (overlong frame) goes to DISCARD plus frame_err.
REQ-020 DISCARD: non-TERM bytes are ignored with no further frame_err; TERM goes to IDLE.
REQ-021 Commit: chr_cmd, chr_val0 and chr_val1 load atomically on the edge that accepts TERM, and rx_msg_done rises on that same edge; latency is 1 cycle from the TERM strobe.
REQ-022 chr_* values change only on commit; erroneous frames leave them unchanged.
REQ-023 rx_msg_done falls on the edge that accepts any subsequent byte, TERM included; it is unaffected by errors or timeout.
REQ-024 Timeout counter (width ceil(log2(TIMEOUT_CYCLES+1))) clears on every rx_valid and counts while the FSM is not IDLE.
REQ-025 When the counter reaches TIMEOUT_CYCLES, the FSM returns to IDLE.
REQ-026 Timeout from GOT_CMD, GOT_V0 or GOT_V1 pulses frame_err; timeout from DISCARD does not.
REQ-027 Counter saturates; it never wraps.
REQ-028 rx_valid on the cycle the timeout would expire: the byte wins and is processed in the current state, with no timeout.
REQ-029 A legal CMD byte arriving mid-frame is treated as a value byte and is subject to the value rules.

Reset
REQ-030 Asynchronous on rst_n low: FSM goes to IDLE and the timeout counter clears.
REQ-031 Reset values: chr_cmd, chr_val0 and chr_val1 = 0x20 (space); rx_msg_done = 0; frame_err = 0.
REQ-032 Reset mid-frame discards the partial frame with no frame_err.
REQ-033 After rst_n deasserts, the first rx_valid may be accepted on the next rising edge.

Configuration
REQ-034 Macro PARSER_STATS_EN.
REQ-035 PARSER_STATS_EN defined: add output frame_cnt (8 bits) and output err_cnt (8 bits).
REQ-036 frame_cnt increments on each commit; err_cnt increments on each frame_err pulse.
REQ-037 Both counters saturate at 0xFF and reset to 0.
REQ-038 PARSER_STATS_EN undefined: neither port exists and no counter logic is present; all other behaviour is identical.

Verification
REQ-039 Bytes "A18\n" -> 1 cycle after the '\n' strobe, chr_cmd=0x41, chr_val0=0x31, chr_val1=0x38, rx_msg_done=1.
REQ-040 "L10\r", then byte 'B' -> chr_* = 'L','1','0'; rx_msg_done falls on the 'B' edge.
REQ-041 "X12\n" -> frame_err pulses once on the 'X' byte; chr_* unchanged; rx_msg_done stays 0.
REQ-042 "C3" then silence for TIMEOUT_CYCLES -> frame_err pulse, FSM in IDLE; a following "D-5\n" commits 'D','-','5'.
REQ-043 "A123\n" -> frame_err on '3', no commit; rst_n pulsed low mid "B0" -> chr_* = 0x20 and no frame_err.
REQ-044 With PARSER_STATS_EN: 300 valid frames -> frame_cnt=0xFF; 2 bad frames -> err_cnt=2.
